// File: rtl/complex_matrix_pipe.sv
// complex_matrix_pipe
//   Three-stage pipelined 2x2 complex fixed-point matrix multiplier,
//   R = op(A) x op(B), where op() is identity or conjugate transpose.
//   Components are W-bit two's complement with FRAC fractional bits.
//   The result is rounded (ROUND=1: half-up, ROUND=0: truncate) and
//   saturated to W bits.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   in_valid     input matrices valid
//   in_ready     block accepts an input this cycle
//   adj_a/adj_b  use conjugate transpose of A/B (sampled with the input)
//   mtx_a/mtx_b  packed inputs; element (r,c,k) at [((r*2+c)*2+k)*W +: W],
//                k=0 real, k=1 imag
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   mtx_r        packed result, same packing
//   out_sat      some component of mtx_r was clamped (with out_valid)
//   sat_sticky   set when a saturated result is delivered
//   sat_clear    clears sat_sticky (a simultaneous set wins)
module complex_matrix_pipe #(
   parameter int W     = 19,
   parameter int FRAC  = 17,
   parameter int ROUND = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           adj_a,
   input  logic           adj_b,
   input  logic [8*W-1:0] mtx_a,
   input  logic [8*W-1:0] mtx_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [8*W-1:0] mtx_r,
   output logic           out_sat,
   output logic           sat_sticky,
   input  logic           sat_clear
);
   localparam int EW = W + 1;       // one extra bit so negating -2^(W-1) cannot wrap
   localparam int PW = 2*W + 2;     // product width
   localparam int SW = 2*W + 4;     // accumulator width (sum of four products)
   localparam logic signed [SW-1:0] RND_BIAS = (ROUND != 0) ? (SW'(1) <<< (FRAC-1)) : '0;
   localparam logic signed [SW-1:0] SAT_MAX  = (SW'(1) <<< (W-1)) - SW'(1);
   localparam logic signed [SW-1:0] SAT_MIN  = -(SW'(1) <<< (W-1));

   // sign-extended component idx (0..7) of a packed matrix
   function automatic logic signed [EW-1:0] elem(input logic [8*W-1:0] m, input int idx);
      return EW'($signed(m[idx*W +: W]));
   endfunction

   // element index (c,r) feeding destination (r,c) under transposition
   function automatic int tr(input int e);
      return (e % 2) * 2 + e / 2;
   endfunction

   logic out_valid_reg;
   logic out_sat_reg;
   logic sat_sticky_reg;
   logic advance;

   // the whole pipe moves in lock-step; only a stalled full output blocks it
   assign advance  = !out_valid_reg || out_ready;
   assign in_ready = advance && !reset;

   // ---------------- S0: capture op(A), op(B) ----------------
   logic                 v0_reg;
   logic signed [EW-1:0] opa_re_reg [4];
   logic signed [EW-1:0] opa_im_reg [4];
   logic signed [EW-1:0] opb_re_reg [4];
   logic signed [EW-1:0] opb_im_reg [4];
   logic signed [EW-1:0] opa_re_next [4];
   logic signed [EW-1:0] opa_im_next [4];
   logic signed [EW-1:0] opb_re_next [4];
   logic signed [EW-1:0] opb_im_next [4];

   always_comb begin
      for (int e = 0; e < 4; e++) begin
         opa_re_next[e] = adj_a ? elem(mtx_a, 2*tr(e))      : elem(mtx_a, 2*e);
         opa_im_next[e] = adj_a ? -elem(mtx_a, 2*tr(e) + 1) : elem(mtx_a, 2*e + 1);
         opb_re_next[e] = adj_b ? elem(mtx_b, 2*tr(e))      : elem(mtx_b, 2*e);
         opb_im_next[e] = adj_b ? -elem(mtx_b, 2*tr(e) + 1) : elem(mtx_b, 2*e + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         v0_reg <= 1'b0;
      else if (advance)
         v0_reg <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         for (int e = 0; e < 4; e++) begin
            opa_re_reg[e] <= opa_re_next[e];
            opa_im_reg[e] <= opa_im_next[e];
            opb_re_reg[e] <= opb_re_next[e];
            opb_im_reg[e] <= opb_im_next[e];
         end
      end
   end

   // ---------------- S1: 32 real partial products ----------------
   // prod_reg[((r*2+c)*2+i)*4 + k], k: 0 ar*br, 1 ai*bi, 2 ar*bi, 3 ai*br
   logic                 v1_reg;
   logic signed [PW-1:0] prod_reg [32];

   always_ff @(posedge clk) begin
      if (reset)
         v1_reg <= 1'b0;
      else if (advance)
         v1_reg <= v0_reg;
   end

   always_ff @(posedge clk) begin
      if (advance && v0_reg) begin
         for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
               for (int i = 0; i < 2; i++) begin
                  prod_reg[((r*2+c)*2+i)*4 + 0] <= PW'(opa_re_reg[r*2+i]) * PW'(opb_re_reg[i*2+c]);
                  prod_reg[((r*2+c)*2+i)*4 + 1] <= PW'(opa_im_reg[r*2+i]) * PW'(opb_im_reg[i*2+c]);
                  prod_reg[((r*2+c)*2+i)*4 + 2] <= PW'(opa_re_reg[r*2+i]) * PW'(opb_im_reg[i*2+c]);
                  prod_reg[((r*2+c)*2+i)*4 + 3] <= PW'(opa_im_reg[r*2+i]) * PW'(opb_re_reg[i*2+c]);
               end
            end
         end
      end
   end

   // ---------------- S2: sum, round, saturate ----------------
   logic signed [SW-1:0] acc_re;
   logic signed [SW-1:0] acc_im;
   logic signed [SW-1:0] rnd;
   logic signed [SW-1:0] comp [8];
   logic        [W-1:0]  res_next [8];
   logic        [W-1:0]  res_reg [8];
   logic                 sat_next;

   always_comb begin
      acc_re   = '0;
      acc_im   = '0;
      rnd      = '0;
      sat_next = 1'b0;
      for (int k = 0; k < 8; k++) begin
         comp[k]     = '0;
         res_next[k] = '0;
      end
      for (int e = 0; e < 4; e++) begin
         acc_re = '0;
         acc_im = '0;
         for (int i = 0; i < 2; i++) begin
            acc_re = acc_re + SW'(prod_reg[(e*2+i)*4 + 0]) - SW'(prod_reg[(e*2+i)*4 + 1]);
            acc_im = acc_im + SW'(prod_reg[(e*2+i)*4 + 2]) + SW'(prod_reg[(e*2+i)*4 + 3]);
         end
         comp[2*e]     = acc_re;
         comp[2*e + 1] = acc_im;
      end
      for (int k = 0; k < 8; k++) begin
         rnd = (comp[k] + RND_BIAS) >>> FRAC;
         if (rnd > SAT_MAX) begin
            res_next[k] = SAT_MAX[W-1:0];
            sat_next    = 1'b1;
         end else if (rnd < SAT_MIN) begin
            res_next[k] = SAT_MIN[W-1:0];
            sat_next    = 1'b1;
         end else begin
            res_next[k] = rnd[W-1:0];
         end
      end
   end

   // bubbles leave the last result on mtx_r; only valid data overwrites it
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_sat_reg   <= 1'b0;
         for (int k = 0; k < 8; k++)
            res_reg[k] <= '0;
      end else if (advance) begin
         out_valid_reg <= v1_reg;
         if (v1_reg) begin
            out_sat_reg <= sat_next;
            for (int k = 0; k < 8; k++)
               res_reg[k] <= res_next[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         sat_sticky_reg <= 1'b0;
      else if (out_valid_reg && out_ready && out_sat_reg)
         sat_sticky_reg <= 1'b1;
      else if (sat_clear)
         sat_sticky_reg <= 1'b0;
   end

   assign out_valid  = out_valid_reg;
   assign out_sat    = out_sat_reg;
   assign sat_sticky = sat_sticky_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pack
         assign mtx_r[gi*W +: W] = res_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_complex_matrix_pipe.sv
// tb_complex_matrix_pipe
//   Self-checking bench for complex_matrix_pipe: hand-computed vector table,
//   reset/back-pressure/sticky sequences, and a randomized stream checked
//   against a complex-arithmetic reference model.
module tb_complex_matrix_pipe;
   localparam int W     = 19;
   localparam int FRAC  = 17;
   localparam int ROUND = 1;
   localparam int MW    = 8*W;
   localparam int NRAND = 60;
   localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (W-1));

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready, adj_a, adj_b;
   logic          out_valid, out_ready, out_sat, sat_sticky, sat_clear;
   logic [MW-1:0] mtx_a, mtx_b, mtx_r;

   always #5 clk = ~clk;

   complex_matrix_pipe #(.W(W), .FRAC(FRAC), .ROUND(ROUND)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .adj_a      (adj_a),
      .adj_b      (adj_b),
      .mtx_a      (mtx_a),
      .mtx_b      (mtx_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .mtx_r      (mtx_r),
      .out_sat    (out_sat),
      .sat_sticky (sat_sticky),
      .sat_clear  (sat_clear)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit sticky_exp = 1'b0;

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   // pack components: e = r*2+c, each as (real, imag)
   function automatic logic [MW-1:0] cm(input int e0r, input int e0i, input int e1r, input int e1i,
                                        input int e2r, input int e2i, input int e3r, input int e3i);
      return {W'(e3i), W'(e3r), W'(e2i), W'(e2r), W'(e1i), W'(e1r), W'(e0i), W'(e0r)};
   endfunction

   function automatic int rc();
      if ($urandom_range(0, 1) == 1)
         return int'($urandom_range(0, 524287)) - 262144;
      else
         return int'($urandom_range(0, 262143)) - 131072;
   endfunction

   function automatic logic [MW-1:0] rm();
      return cm(rc(), rc(), rc(), rc(), rc(), rc(), rc(), rc());
   endfunction

   // Reference: plain complex matrix product with round-half-up and clamp.
   function automatic void model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 input bit aa, input bit ab,
                                 output logic [MW-1:0] r, output bit sat);
      longint ar [2][2];
      longint ai [2][2];
      longint br [2][2];
      longint bi [2][2];
      longint comp [8];
      longint v;
      int     ea, eb;
      sat = 1'b0;
      r   = '0;
      for (int x = 0; x < 2; x++) begin
         for (int y = 0; y < 2; y++) begin
            ea = aa ? (y*2 + x) : (x*2 + y);
            eb = ab ? (y*2 + x) : (x*2 + y);
            ar[x][y] = longint'($signed(a[(2*ea)*W +: W]));
            ai[x][y] = longint'($signed(a[(2*ea+1)*W +: W]));
            br[x][y] = longint'($signed(b[(2*eb)*W +: W]));
            bi[x][y] = longint'($signed(b[(2*eb+1)*W +: W]));
            if (aa) ai[x][y] = -ai[x][y];
            if (ab) bi[x][y] = -bi[x][y];
         end
      end
      for (int x = 0; x < 2; x++) begin
         for (int y = 0; y < 2; y++) begin
            comp[(x*2+y)*2]     = 0;
            comp[(x*2+y)*2 + 1] = 0;
            for (int i = 0; i < 2; i++) begin
               comp[(x*2+y)*2]     += ar[x][i]*br[i][y] - ai[x][i]*bi[i][y];
               comp[(x*2+y)*2 + 1] += ar[x][i]*bi[i][y] + ai[x][i]*br[i][y];
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         v = comp[k];
         if (ROUND != 0) v = v + (64'sd1 <<< (FRAC-1));
         v = v >>> FRAC;
         if (v > MAXV) begin v = MAXV; sat = 1'b1; end
         else if (v < MINV) begin v = MINV; sat = 1'b1; end
         r[k*W +: W] = W'(v);
      end
   endfunction

   typedef struct {
      logic [MW-1:0] a;
      logic [MW-1:0] b;
      bit            aa;
      bit            ab;
      bit            clr;
      logic [MW-1:0] r;
      bit            sat;
   } vec_t;

   vec_t tbl [8];

   // One transaction on an otherwise idle pipe; lat = edges after acceptance until out_valid.
   task automatic run_one(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit aa, input bit ab,
                          input bit clr, output logic [MW-1:0] r, output bit s, output int lat);
      @(negedge clk);
      mtx_a = a; mtx_b = b; adj_a = aa; adj_b = ab;
      in_valid = 1'b1; out_ready = 1'b1; sat_clear = clr;
      #1;
      chk1("in_ready idle", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      r = mtx_r;
      s = out_sat;
      @(posedge clk);
      @(negedge clk);
      sat_clear = 1'b0;
   endtask

   logic [MW-1:0] res_r, er, ca, cb, held_r;
   bit            res_s, es, caa, cab, held_s, have, held, acc;
   int            lat, sent, got, idx;
   logic [MW-1:0] exp_q [$];
   bit            sat_q [$];
   logic [MW-1:0] sm_a [4];
   logic [MW-1:0] sm_b [4];
   logic [MW-1:0] se [4];
   bit            ss [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- vector table (hand-computed results) ----
      tbl[0] = '{cm(131072,0, 0,0, 0,0, 131072,0), cm(74565,-5000, 1000,2000, -3000,4000, 50000,-70000),
                 1'b0, 1'b0, 1'b0, cm(74565,-5000, 1000,2000, -3000,4000, 50000,-70000), 1'b0};
      tbl[1] = '{cm(131072,0, 0,0, 0,0, 131072,0), cm(100,200, 300,400, 500,600, 700,800),
                 1'b0, 1'b1, 1'b0, cm(100,-200, 500,-600, 300,-400, 700,-800), 1'b0};
      tbl[2] = '{cm(92682,0, 92682,0, 92682,0, -92682,0), cm(92682,0, 92682,0, 92682,0, -92682,0),
                 1'b0, 1'b0, 1'b0, cm(131072,0, 0,0, 0,0, 131072,0), 1'b0};
      tbl[3] = '{cm(0,131072, 0,0, 0,0, 0,131072), cm(0,131072, 0,0, 0,0, 0,131072),
                 1'b0, 1'b0, 1'b0, cm(-131072,0, 0,0, 0,0, -131072,0), 1'b0};
      tbl[4] = '{cm(0,131072, 0,0, 0,0, 0,131072), cm(131072,0, 0,0, 0,0, 131072,0),
                 1'b1, 1'b0, 1'b0, cm(0,-131072, 0,0, 0,0, 0,-131072), 1'b0};
      tbl[5] = '{cm(65536,0, 0,0, 0,0, 65536,0), cm(3,0, -3,0, 1,1, -1,-1),
                 1'b0, 1'b0, 1'b0, cm(2,0, -1,0, 1,1, 0,0), 1'b0};
      tbl[6] = '{cm(262143,0, 262143,0, 0,0, 0,0), cm(262143,0, 0,0, 262143,0, 0,0),
                 1'b0, 1'b0, 1'b0, cm(262143,0, 0,0, 0,0, 0,0), 1'b1};
      tbl[7] = '{cm(0,-262144, 0,0, 0,0, 0,0), cm(131072,0, 0,0, 0,0, 131072,0),
                 1'b1, 1'b0, 1'b1, cm(0,262143, 0,0, 0,0, 0,0), 1'b1};

      // ---- reset state ----
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
      adj_a = 1'b0; adj_b = 1'b0; mtx_a = '0; mtx_b = '0;
      repeat (2) @(negedge clk);
      chk1("in_ready in reset", in_ready, 1'b0);
      chk1("out_valid after reset", out_valid, 1'b0);
      chk("mtx_r after reset", mtx_r, '0);
      chk1("out_sat after reset", out_sat, 1'b0);
      chk1("sat_sticky after reset", sat_sticky, 1'b0);
      reset = 1'b0;
      #1;
      chk1("in_ready after reset", in_ready, 1'b1);

      // ---- table-driven vectors ----
      for (int k = 0; k < 8; k++) begin
         run_one(tbl[k].a, tbl[k].b, tbl[k].aa, tbl[k].ab, tbl[k].clr, res_r, res_s, lat);
         chk($sformatf("vec%0d latency", k), MW'(lat), MW'(2));
         chk($sformatf("vec%0d mtx_r", k), res_r, tbl[k].r);
         chk1($sformatf("vec%0d out_sat", k), res_s, tbl[k].sat);
         sticky_exp = tbl[k].sat ? 1'b1 : (tbl[k].clr ? 1'b0 : sticky_exp);
         chk1($sformatf("vec%0d sat_sticky", k), sat_sticky, sticky_exp);
         $display("vec %0d: adj=%0d%0d r=%h sat=%0d lat=%0d", k, tbl[k].aa, tbl[k].ab, res_r, res_s, lat);
      end

      // ---- reset one cycle after acceptance ----
      @(negedge clk);
      mtx_a = tbl[0].a; mtx_b = tbl[0].b; adj_a = 1'b0; adj_b = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk1("rst: in_ready before", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      #1;
      chk1("rst: in_ready during reset", in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sticky_exp = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk1("rst: out_valid", out_valid, 1'b0);
         chk("rst: mtx_r", mtx_r, '0);
         chk1("rst: out_sat", out_sat, 1'b0);
         chk1("rst: sat_sticky", sat_sticky, 1'b0);
         @(negedge clk);
      end
      $display("reset-in-flight: outputs stayed 0");

      // ---- randomized stream with random gaps and back-pressure ----
      sent = 0; got = 0; have = 1'b0; held = 1'b0;
      for (int cyc = 0; cyc < 3000 && got < NRAND; cyc++) begin
         @(negedge clk);
         if (!have && sent < NRAND && $urandom_range(0, 3) != 0) begin
            ca = rm(); cb = rm();
            caa = 1'($urandom_range(0, 1)); cab = 1'($urandom_range(0, 1));
            have = 1'b1;
         end
         in_valid = have; mtx_a = ca; mtx_b = cb; adj_a = caa; adj_b = cab;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (held) begin
            chk1("hold out_valid", out_valid, 1'b1);
            chk("hold mtx_r", mtx_r, held_r);
            chk1("hold out_sat", out_sat, held_s);
         end
         held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL stream: unexpected output %h, required none", mtx_r);
               end else begin
                  er = exp_q.pop_front();
                  es = sat_q.pop_front();
                  chk($sformatf("stream%0d mtx_r", got), mtx_r, er);
                  chk1($sformatf("stream%0d out_sat", got), out_sat, es);
                  if (es) sticky_exp = 1'b1;
                  $display("stream %0d: r=%h sat=%0d", got, mtx_r, out_sat);
                  got++;
               end
            end else begin
               held = 1'b1; held_r = mtx_r; held_s = out_sat;
            end
         end
         if (in_valid && in_ready) begin
            model(ca, cb, caa, cab, er, es);
            exp_q.push_back(er);
            sat_q.push_back(es);
            sent++;
            have = 1'b0;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream delivered", MW'(got), MW'(NRAND));
      chk1("stream sat_sticky", sat_sticky, sticky_exp);

      // ---- four inputs, output stalled for 5 cycles ----
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sm_a[k] = rm(); sm_b[k] = rm();
         model(sm_a[k], sm_b[k], 1'b0, 1'b1, se[k], ss[k]);
      end
      adj_a = 1'b0; adj_b = 1'b1;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) break;
         in_valid = 1'b1; mtx_a = sm_a[idx]; mtx_b = sm_b[idx];
         #1;
         acc = in_ready;
         @(posedge clk);
         if (acc) idx++;
      end
      chk("stall: accepted before full", MW'(idx), MW'(3));
      in_valid = 1'b1; mtx_a = sm_a[3]; mtx_b = sm_b[3];
      for (int s = 0; s < 5; s++) begin
         #1;
         chk1("stall: in_ready", in_ready, 1'b0);
         chk1("stall: out_valid", out_valid, 1'b1);
         chk("stall: mtx_r", mtx_r, se[0]);
         chk1("stall: out_sat", out_sat, ss[0]);
         @(negedge clk);
      end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         #1;
         if (out_valid) begin
            chk($sformatf("drain%0d mtx_r", got), mtx_r, se[got]);
            chk1($sformatf("drain%0d out_sat", got), out_sat, ss[got]);
            if (ss[got]) sticky_exp = 1'b1;
            $display("drain %0d: r=%h sat=%0d", got, mtx_r, out_sat);
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) idx++;
         @(negedge clk);
         if (idx < 4) begin
            mtx_a = sm_a[idx]; mtx_b = sm_b[idx];
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("drain: delivered", MW'(got), MW'(4));
      chk("drain: accepted", MW'(idx), MW'(4));

      // ---- sticky set then clear ----
      run_one(tbl[6].a, tbl[6].b, 1'b0, 1'b0, 1'b0, res_r, res_s, lat);
      chk("sticky: sat result", res_r, tbl[6].r);
      chk1("sticky: set", sat_sticky, 1'b1);
      @(negedge clk);
      sat_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sat_clear = 1'b0;
      #1;
      chk1("sticky: cleared", sat_sticky, 1'b0);
      $display("sticky: set then cleared");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
